// File: rtl/xeng_window_ctrl_pkg.sv
// Shared definitions for the X-engine window controller: FSM state encoding
// and the helpers that derive the window period and window-counter width.
package xeng_window_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } xeng_state_t;

  // Cycles per window: every antenna contributes 2^acc_bits samples.
  function automatic int unsigned xeng_period(input int unsigned acc_bits,
                                              input int unsigned n_ants);
    return n_ants << acc_bits;
  endfunction

  // Width of the window counter {antenna, sample}.
  function automatic int unsigned xeng_cnt_width(input int unsigned acc_bits,
                                                 input int unsigned n_ants);
    return acc_bits + $clog2(n_ants);
  endfunction

endpackage

// File: rtl/xeng_ctrl_delay.sv
// Resettable shift register used to align the read strobe and the sync
// request with the data coming back from the window buffer.
//   clk, rst : clock and synchronous active-high reset (clears every stage)
//   din      : value entering the first stage
//   dout     : value leaving the last stage, STAGES cycles later
module xeng_ctrl_delay #(
  parameter int unsigned STAGES = 1,
  parameter int unsigned WIDTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned SW = STAGES * WIDTH;

  logic [SW-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= SW'({sr, din});
  end

  assign dout = sr[SW-1 -: WIDTH];

endmodule

// File: rtl/xeng_window_ctrl.sv
// Window controller between the antenna window buffer and the X-engine.
// Arms on en & win_rdy, issues one xeng_sync, then streams back-to-back
// windows of N_ANTS * 2^SERIAL_ACC_LEN_BITS read cycles until en drops at a
// window boundary. Windows not ready at their first cycle are skipped whole.
//   clk, rst          : clock, synchronous active-high reset
//   en                : run enable (honoured only at window boundaries)
//   win_rdy, win_mcnt : buffer holds a window / its mcnt timestamp
//   win_ack           : pulse, window claimed
//   rd_en, rd_ant, rd_addr : buffer read strobe and {antenna, sample} index
//   xeng_sync, xeng_vld, xeng_mcnt : X-engine control, aligned to buffer data
//   busy              : controller armed (not idle)
//   win_cnt, skip_cnt : wrapping counts of issued / skipped windows
// RD_LATENCY must be at least 2.
module xeng_window_ctrl
  import xeng_window_ctrl_pkg::*;
#(
  parameter int unsigned SERIAL_ACC_LEN_BITS = 7,
  parameter int unsigned N_ANTS              = 32,
  parameter int unsigned MCNT_WIDTH          = 48,
  parameter int unsigned RD_LATENCY          = 2,
  parameter int unsigned CNT_WIDTH           = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           win_rdy,
  input  logic [MCNT_WIDTH-1:0]          win_mcnt,
  output logic                           win_ack,
  output logic                           rd_en,
  output logic [$clog2(N_ANTS)-1:0]      rd_ant,
  output logic [SERIAL_ACC_LEN_BITS-1:0] rd_addr,
  output logic                           xeng_sync,
  output logic                           xeng_vld,
  output logic [MCNT_WIDTH-1:0]          xeng_mcnt,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           win_cnt,
  output logic [CNT_WIDTH-1:0]           skip_cnt
);

  localparam int unsigned ANT_BITS = $clog2(N_ANTS);
  localparam int unsigned PERIOD   = xeng_period(SERIAL_ACC_LEN_BITS, N_ANTS);
  localparam int unsigned CW       = xeng_cnt_width(SERIAL_ACC_LEN_BITS, N_ANTS);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  xeng_state_t           state;
  logic [CW-1:0]         cnt;
  logic                  live;
  logic                  first;
  logic [MCNT_WIDTH-1:0] mcnt;
  logic                  win_start;
  logic                  sync_req;
  logic [1:0]            dly_out;

  // The live/skip decision is taken on the window's first cycle, so the
  // read strobe for that cycle follows win_rdy directly; afterwards the
  // latched decision holds and win_rdy is ignored until the next boundary.
  assign win_start = (state == ST_RUN) && (cnt == '0);
  assign win_ack   = win_start && win_rdy;
  assign rd_en     = (state == ST_RUN) && (win_start ? win_rdy : live);
  assign rd_ant    = cnt[CW-1 -: ANT_BITS];
  assign rd_addr   = cnt[SERIAL_ACC_LEN_BITS-1:0];
  assign sync_req  = (state == ST_SYNC);
  assign busy      = (state != ST_IDLE);
  assign xeng_mcnt = mcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      live     <= 1'b0;
      first    <= 1'b0;
      mcnt     <= '0;
      win_cnt  <= '0;
      skip_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && win_rdy) state <= ST_SYNC;
        end
        ST_SYNC: begin
          mcnt  <= win_mcnt;
          first <= 1'b1;
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (win_start) begin
            live  <= win_rdy;
            first <= 1'b0;
            if (win_rdy) begin
              win_cnt <= win_cnt + 1'b1;
              // the armed window's mcnt was already taken in SYNC
              if (!first) mcnt <= win_mcnt;
            end else begin
              skip_cnt <= skip_cnt + 1'b1;
            end
          end
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!en) begin
              state <= ST_IDLE;
              live  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // rd_en is decoded from registered state and the buffer registers it on
  // the next edge, so one cycle of RD_LATENCY is already spent at that point.
  xeng_ctrl_delay #(
    .STAGES(RD_LATENCY - 1),
    .WIDTH (2)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .din ({rd_en, sync_req}),
    .dout(dly_out)
  );

  assign xeng_vld  = dly_out[1];
  assign xeng_sync = dly_out[0];

endmodule

// File: tb/tb_xeng_window_ctrl.sv
// Scoreboard bench for xeng_window_ctrl with 4 antennas x 4 samples
// (16-cycle windows), RD_LATENCY=2 and 2-bit status counters.
module tb_xeng_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        win_rdy;
  logic [15:0] win_mcnt;
  logic        win_ack;
  logic        rd_en;
  logic [1:0]  rd_ant;
  logic [1:0]  rd_addr;
  logic        xeng_sync;
  logic        xeng_vld;
  logic [15:0] xeng_mcnt;
  logic        busy;
  logic [1:0]  win_cnt;
  logic [1:0]  skip_cnt;

  xeng_window_ctrl #(
    .SERIAL_ACC_LEN_BITS(2),
    .N_ANTS             (4),
    .MCNT_WIDTH         (16),
    .RD_LATENCY         (2),
    .CNT_WIDTH          (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .win_rdy  (win_rdy),
    .win_mcnt (win_mcnt),
    .win_ack  (win_ack),
    .rd_en    (rd_en),
    .rd_ant   (rd_ant),
    .rd_addr  (rd_addr),
    .xeng_sync(xeng_sync),
    .xeng_vld (xeng_vld),
    .xeng_mcnt(xeng_mcnt),
    .busy     (busy),
    .win_cnt  (win_cnt),
    .skip_cnt (skip_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int unsigned m;
    int          cyc;
    int          len;
  } win_exp_t;

  typedef struct {
    int          cyc;
    int unsigned m;
  } sync_exp_t;

  win_exp_t  win_q[$];
  sync_exp_t sync_q[$];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_win_ack"},   win_ack,   0);
    check_eq({tag, "_rd_en"},     rd_en,     0);
    check_eq({tag, "_rd_ant"},    rd_ant,    0);
    check_eq({tag, "_rd_addr"},   rd_addr,   0);
    check_eq({tag, "_xeng_sync"}, xeng_sync, 0);
    check_eq({tag, "_xeng_vld"},  xeng_vld,  0);
    check_eq({tag, "_xeng_mcnt"}, xeng_mcnt, 0);
    check_eq({tag, "_busy"},      busy,      0);
    check_eq({tag, "_win_cnt"},   win_cnt,   0);
    check_eq({tag, "_skip_cnt"},  skip_cnt,  0);
  endtask

  // Entered just after the edge that starts the window (cnt=0). win_rdy is
  // flipped at cnt=3 to show mid-window changes are ignored.
  task automatic run_window(input bit rdy, input int unsigned m, input int exp_vld,
                            input int exp_len, input int stop_at, input int rst_at);
    win_rdy  = rdy;
    win_mcnt = 16'(m);
    if (rdy) win_q.push_back('{m: m, cyc: exp_vld, len: exp_len});
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      if (k == 3) begin
        win_rdy  = !rdy;
        win_mcnt = 16'(m + 50);
      end
      if (k == stop_at) en = 1'b0;
      if (k == rst_at) rst = 1'b1;
      @(negedge clk);
      if (k == 0) check_eq("win_ack", win_ack, rdy);
      check_eq("rd_en", rd_en, rdy);
      if (k == rst_at) return;
    end
  endtask

  // Output monitor: sync and window-valid timing, mcnt, window length and
  // the sample-major / antenna-major read order.
  win_exp_t   cur = '{m: 0, cyc: 0, len: 0};
  int         run_len = 0;
  bit         prev_vld = 1'b0;
  logic [3:0] rd_idx = '0;

  always @(negedge clk) begin
    if (xeng_sync) begin
      check_eq("sync_has_exp", sync_q.size() != 0, 1);
      if (sync_q.size() != 0) begin
        sync_exp_t s;
        s = sync_q.pop_front();
        check_eq("sync_cycle", cyc, s.cyc);
        check_eq("mcnt_at_sync", xeng_mcnt, s.m);
      end
    end
    if (xeng_vld) begin
      if (!prev_vld || run_len == 16) begin
        check_eq("vld_has_exp", win_q.size() != 0, 1);
        if (win_q.size() != 0) begin
          cur = win_q.pop_front();
          check_eq("vld_start", cyc, cur.cyc);
          check_eq("xeng_mcnt", xeng_mcnt, cur.m);
        end
        run_len = 1;
      end else begin
        run_len++;
      end
    end else if (prev_vld) begin
      check_eq("vld_len", run_len, cur.len);
    end
    prev_vld = xeng_vld;
    if (rd_en) begin
      check_eq("rd_ant_addr", {rd_ant, rd_addr}, rd_idx);
      rd_idx = rd_idx + 1'b1;
    end else begin
      rd_idx = '0;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete in time");
    n_err++;
    finish_run();
  end

  int c0;
  int c1;

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    win_rdy  = 1'b0;
    win_mcnt = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Arm: SYNC one cycle later, sync at +2, first window vld from +3.
    tick();
    c0       = cyc;
    en       = 1'b1;
    win_rdy  = 1'b1;
    win_mcnt = 16'd100;
    sync_q.push_back('{cyc: c0 + 2, m: 100});
    @(negedge clk);
    check_eq("arm_busy_idle", busy, 0);
    tick();
    @(negedge clk);
    check_eq("sync_busy", busy, 1);
    check_eq("sync_rd_en", rd_en, 0);
    tick();
    run_window(1'b1, 100, c0 + 3, 16, -1, -1);

    // Skipped window; the next live one lands exactly 32 cycles after the first.
    tick();
    run_window(1'b0, 0, 0, 0, -1, -1);
    check_eq("mcnt_hold_skip", xeng_mcnt, 100);
    tick();
    run_window(1'b1, 101, c0 + 35, 16, -1, -1);
    check_eq("skip_cnt", skip_cnt, 1);
    check_eq("win_cnt_after_skip", win_cnt, 2);

    // Stop: en dropped at cnt=5, window still runs all 16 reads.
    tick();
    run_window(1'b1, 102, c0 + 51, 16, 5, -1);
    tick();
    win_rdy = 1'b0;
    @(negedge clk);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_rd_en", rd_en, 0);
    check_eq("stop_win_cnt", win_cnt, 3);
    repeat (4) tick();

    // Re-arm: new sync, win_cnt continues (3 -> 0 -> 1 with 2-bit counter).
    c1       = cyc;
    en       = 1'b1;
    win_rdy  = 1'b1;
    win_mcnt = 16'd200;
    sync_q.push_back('{cyc: c1 + 2, m: 200});
    tick();
    tick();
    run_window(1'b1, 200, c1 + 3, 16, -1, -1);
    check_eq("win_cnt_continue", win_cnt, 0);
    tick();
    run_window(1'b1, 201, c1 + 19, 16, -1, -1);
    check_eq("win_cnt_wrap", win_cnt, 1);

    // Reset at cnt=7 aborts the window; vld already in flight is cut to 7.
    tick();
    run_window(1'b1, 202, c1 + 35, 7, -1, 7);
    tick();
    rst     = 1'b0;
    en      = 1'b0;
    win_rdy = 1'b0;
    @(negedge clk);
    check_zero("mid_rst");

    repeat (6) tick();
    check_eq("win_q_left", win_q.size(), 0);
    check_eq("sync_q_left", sync_q.size(), 0);
    finish_run();
  end

endmodule
